// File: rtl/prog_counter.sv
// prog_counter: programmable up/down counter with runtime bounds and a prescaler.
//
// Parameters
//   WIDTH   - count and bound width in bits (1..32)
//   DIV_W   - prescaler divide-select width in bits (1..16)
//   RST_VAL - value of count after reset
//
// Ports
//   clk      in   single clock, rising edge
//   rst_n    in   synchronous active-low reset
//   en       in   enables prescaler advance and counting
//   clr      in   restart at the mode's start value
//   load     in   load load_val (clipped into [min_val, max_val])
//   load_val in   value for load
//   mode     in   0=UP, 1=DOWN, 2=UPSAT, 3=DOWNSAT
//   min_val  in   lower bound, unsigned
//   max_val  in   upper bound, unsigned
//   div      in   one step per div+1 enabled cycles
//   count    out  registered counter value
//   tc       out  registered pulse: last step landed on the terminal value
//   wrap     out  registered pulse: last step wrapped around
//   sat      out  saturating mode and count sits at the terminal value
//   cfg_err  out  min_val > max_val
module prog_counter #(
    parameter int unsigned            WIDTH   = 8,
    parameter int unsigned            DIV_W   = 4,
    parameter logic [WIDTH-1:0]       RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] min_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             sat,
    output logic             cfg_err
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [DIV_W-1:0] psc_q, psc_d;
    logic             tc_q, tc_d;
    logic             wrap_q, wrap_d;

    logic             down_mode;
    logic             sat_mode;
    logic             tick;
    logic [WIDTH-1:0] terminal;
    logic [WIDTH-1:0] start;
    logic [WIDTH-1:0] step_val;
    logic             step_wrap;
    logic             step_tc;
    logic [WIDTH-1:0] load_clip;

    assign down_mode = mode[0];
    assign sat_mode  = mode[1];
    assign terminal  = down_mode ? min_val : max_val;
    assign start     = down_mode ? max_val : min_val;
    assign cfg_err   = (min_val > max_val);
    assign sat       = sat_mode && (count_q == terminal);

    // Equality compare only: if div is lowered below the current prescaler value the
    // prescaler rolls through its full range and comes back round rather than stalling.
    assign tick = en && (psc_q == div);

    always_comb begin
        step_val  = count_q;
        step_wrap = 1'b0;
        if (!down_mode) begin
            // Bound is checked before the increment so count never overflows.
            if (count_q >= max_val) begin
                step_val  = sat_mode ? max_val : min_val;
                step_wrap = !sat_mode;
            end else begin
                step_val = count_q + WIDTH'(1);
            end
        end else begin
            if (count_q <= min_val) begin
                step_val  = sat_mode ? min_val : max_val;
                step_wrap = !sat_mode;
            end else begin
                step_val = count_q - WIDTH'(1);
            end
        end
        // A saturating counter already parked on its terminal value does not re-pulse tc.
        step_tc = (step_val == terminal) && !(sat_mode && (count_q == terminal));
    end

    always_comb begin
        if (load_val < min_val) begin
            load_clip = min_val;
        end else if (load_val > max_val) begin
            load_clip = max_val;
        end else begin
            load_clip = load_val;
        end
    end

    always_comb begin
        count_d = count_q;
        psc_d   = psc_q;
        tc_d    = 1'b0;
        wrap_d  = 1'b0;
        if (clr) begin
            count_d = start;
            psc_d   = '0;
        end else if (load) begin
            // With inconsistent bounds there is no valid range to clip into.
            count_d = cfg_err ? load_val : load_clip;
            psc_d   = '0;
        end else if (en) begin
            psc_d = (psc_q == div) ? '0 : psc_q + DIV_W'(1);
            if (tick && !cfg_err) begin
                count_d = step_val;
                tc_d    = step_tc;
                wrap_d  = step_wrap;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= RST_VAL;
            psc_q   <= '0;
            tc_q    <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            psc_q   <= psc_d;
            tc_q    <= tc_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_prog_counter.sv
// Directed self-checking bench for prog_counter (WIDTH=8, DIV_W=4, RST_VAL=7).
module tb_prog_counter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic       load;
    logic [7:0] load_val;
    logic [1:0] mode;
    logic [7:0] min_val;
    logic [7:0] max_val;
    logic [3:0] div;
    logic [7:0] count;
    logic       tc;
    logic       wrap;
    logic       sat;
    logic       cfg_err;

    int nvec;
    int nerr;

    prog_counter #(
        .WIDTH  (8),
        .DIV_W  (4),
        .RST_VAL(8'd7)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .clr     (clr),
        .load    (load),
        .load_val(load_val),
        .mode    (mode),
        .min_val (min_val),
        .max_val (max_val),
        .div     (div),
        .count   (count),
        .tc      (tc),
        .wrap    (wrap),
        .sat     (sat),
        .cfg_err (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; clr = 1'b1; load = 1'b1; load_val = 8'd3;
        cyc();
        nvec++;
        if (count !== 8'd7) begin
            nerr++; $display("FAIL reset_count got %0d want 7", count);
        end
        nvec++;
        if (tc !== 1'b0 || wrap !== 1'b0) begin
            nerr++; $display("FAIL reset_pulses got tc=%b wrap=%b want 0 0", tc, wrap);
        end
        nvec++;
        if (cfg_err !== 1'b0) begin
            nerr++; $display("FAIL reset_cfg_err got %b want 0", cfg_err);
        end
        rst_n = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0;
        cyc();
    endtask

    task automatic test_up_wrap();
        logic [7:0] ec [4];
        logic       et [4];
        logic       ew [4];
        ec = '{8'd4, 8'd5, 8'd6, 8'd3};
        et = '{1'b0, 1'b0, 1'b1, 1'b0};
        ew = '{1'b0, 1'b0, 1'b0, 1'b1};
        mode = 2'd0; min_val = 8'd3; max_val = 8'd6; div = 4'd0;
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        nvec++;
        if (count !== 8'd3) begin
            nerr++; $display("FAIL up_clr got %0d want 3", count);
        end
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            nvec++;
            if (count !== ec[i] || tc !== et[i] || wrap !== ew[i]) begin
                nerr++;
                $display("FAIL up_step%0d got c=%0d tc=%b w=%b want c=%0d tc=%b w=%b",
                         i, count, tc, wrap, ec[i], et[i], ew[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_down_wrap();
        logic [7:0] ec [4];
        logic       et [4];
        logic       ew [4];
        ec = '{8'd5, 8'd4, 8'd3, 8'd6};
        et = '{1'b0, 1'b0, 1'b1, 1'b0};
        ew = '{1'b0, 1'b0, 1'b0, 1'b1};
        mode = 2'd1; min_val = 8'd3; max_val = 8'd6; div = 4'd0;
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        nvec++;
        if (count !== 8'd6) begin
            nerr++; $display("FAIL down_clr got %0d want 6", count);
        end
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            nvec++;
            if (count !== ec[i] || tc !== et[i] || wrap !== ew[i]) begin
                nerr++;
                $display("FAIL down_step%0d got c=%0d tc=%b w=%b want c=%0d tc=%b w=%b",
                         i, count, tc, wrap, ec[i], et[i], ew[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_prescale();
        logic       ee [4];
        logic [7:0] ec [4];
        ee = '{1'b1, 1'b1, 1'b0, 1'b1};
        ec = '{8'd3, 8'd3, 8'd3, 8'd4};
        mode = 2'd0; min_val = 8'd3; max_val = 8'd6; div = 4'd2;
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            en = ee[i];
            cyc();
            nvec++;
            if (count !== ec[i]) begin
                nerr++; $display("FAIL prescale_cyc%0d got %0d want %0d", i, count, ec[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_downsat();
        logic [7:0] ec [5];
        logic       et [5];
        logic       es [5];
        ec = '{8'd4, 8'd3, 8'd2, 8'd2, 8'd2};
        et = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        es = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        mode = 2'd3; min_val = 8'd2; max_val = 8'd6; div = 4'd0;
        load = 1'b1; load_val = 8'd5;
        cyc();
        load = 1'b0;
        nvec++;
        if (count !== 8'd5 || tc !== 1'b0 || sat !== 1'b0) begin
            nerr++; $display("FAIL downsat_load got c=%0d tc=%b sat=%b want 5 0 0",
                             count, tc, sat);
        end
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            nvec++;
            if (count !== ec[i] || tc !== et[i] || sat !== es[i] || wrap !== 1'b0) begin
                nerr++;
                $display("FAIL downsat_step%0d got c=%0d tc=%b sat=%b w=%b want c=%0d tc=%b sat=%b w=0",
                         i, count, tc, sat, wrap, ec[i], et[i], es[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_upsat();
        mode = 2'd2; min_val = 8'd3; max_val = 8'd6; div = 4'd0;
        load = 1'b1; load_val = 8'd5;
        cyc();
        load = 1'b0; en = 1'b1;
        cyc();
        nvec++;
        if (count !== 8'd6 || tc !== 1'b1 || sat !== 1'b1) begin
            nerr++; $display("FAIL upsat_reach got c=%0d tc=%b sat=%b want 6 1 1", count, tc, sat);
        end
        cyc();
        nvec++;
        if (count !== 8'd6 || tc !== 1'b0 || wrap !== 1'b0 || sat !== 1'b1) begin
            nerr++; $display("FAIL upsat_hold got c=%0d tc=%b w=%b sat=%b want 6 0 0 1",
                             count, tc, wrap, sat);
        end
        en = 1'b0;
    endtask

    task automatic test_priority();
        logic [7:0] ec [3];
        ec = '{8'd1, 8'd1, 8'd2};
        mode = 2'd0; min_val = 8'd1; max_val = 8'd6; div = 4'd2;
        clr = 1'b1;
        cyc();
        clr = 1'b0; en = 1'b1;
        cyc();
        cyc();
        // Prescaler now at div: a tick would fire this cycle.
        clr = 1'b1; load = 1'b1; load_val = 8'd5;
        cyc();
        clr = 1'b0; load = 1'b0;
        nvec++;
        if (count !== 8'd1 || tc !== 1'b0 || wrap !== 1'b0) begin
            nerr++; $display("FAIL priority_clr got c=%0d tc=%b w=%b want 1 0 0", count, tc, wrap);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            nvec++;
            if (count !== ec[i]) begin
                nerr++; $display("FAIL priority_psc%0d got %0d want %0d", i, count, ec[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_load_clip_cfg_err();
        mode = 2'd0; min_val = 8'd1; max_val = 8'd100; div = 4'd0;
        load = 1'b1; load_val = 8'd0;
        cyc();
        nvec++;
        if (count !== 8'd1) begin
            nerr++; $display("FAIL load_clip_low got %0d want 1", count);
        end
        load_val = 8'd200;
        cyc();
        load = 1'b0;
        nvec++;
        if (count !== 8'd100) begin
            nerr++; $display("FAIL load_clip_high got %0d want 100", count);
        end
        min_val = 8'd120;
        #1;
        nvec++;
        if (cfg_err !== 1'b1) begin
            nerr++; $display("FAIL cfg_err_level got %b want 1", cfg_err);
        end
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            nvec++;
            if (count !== 8'd100 || tc !== 1'b0 || wrap !== 1'b0) begin
                nerr++; $display("FAIL cfg_err_frozen%0d got c=%0d tc=%b w=%b want 100 0 0",
                                 i, count, tc, wrap);
            end
        end
        load = 1'b1; load_val = 8'd200;
        cyc();
        load = 1'b0; en = 1'b0;
        nvec++;
        if (count !== 8'd200) begin
            nerr++; $display("FAIL cfg_err_load got %0d want 200", count);
        end
        min_val = 8'd0; max_val = 8'd255;
    endtask

    task automatic test_equal_bounds();
        mode = 2'd0; min_val = 8'd9; max_val = 8'd9; div = 4'd0;
        clr = 1'b1;
        cyc();
        clr = 1'b0; en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            nvec++;
            if (count !== 8'd9 || tc !== 1'b1) begin
                nerr++; $display("FAIL equal_bounds%0d got c=%0d tc=%b want 9 1", i, count, tc);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_div_lowered();
        mode = 2'd0; min_val = 8'd3; max_val = 8'd6; div = 4'd5;
        clr = 1'b1;
        cyc();
        clr = 1'b0; en = 1'b1;
        cyc(); cyc(); cyc();
        // Prescaler at 3; div now 1 so it must roll 3..15,0,1 (15 cycles) before stepping.
        div = 4'd1;
        for (int i = 0; i < 14; i++) cyc();
        nvec++;
        if (count !== 8'd3) begin
            nerr++; $display("FAIL div_lowered_early got %0d want 3", count);
        end
        cyc();
        nvec++;
        if (count !== 8'd4) begin
            nerr++; $display("FAIL div_lowered_step got %0d want 4", count);
        end
        en = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [7:0] ec [3];
        ec = '{8'd7, 8'd7, 8'd8};
        mode = 2'd0; min_val = 8'd3; max_val = 8'd200; div = 4'd2;
        clr = 1'b1;
        cyc();
        clr = 1'b0; en = 1'b1;
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        nvec++;
        if (count !== 8'd7 || tc !== 1'b0 || wrap !== 1'b0) begin
            nerr++; $display("FAIL mid_reset got c=%0d tc=%b w=%b want 7 0 0", count, tc, wrap);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            nvec++;
            if (count !== ec[i]) begin
                nerr++; $display("FAIL mid_reset_resume%0d got %0d want %0d", i, count, ec[i]);
            end
        end
        en = 1'b0;
    endtask

    initial begin
        nvec = 0; nerr = 0;
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
        mode = 2'd0; min_val = 8'd0; max_val = 8'd255; div = 4'd0;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_prescale();
        test_downsat();
        test_upsat();
        test_priority();
        test_load_clip_cfg_err();
        test_equal_bounds();
        test_div_lowered();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
